// File: rtl/snapshot_bank.sv
// Circular history of CHANNELS x WIDTH display snapshots with a live
// pass-through mode and a browse mode that steps through older/newer entries.
module snapshot_bank #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS*WIDTH-1:0]     value_in,
  input  logic                          store,
  input  logic                          recall,
  input  logic                          prev,
  input  logic                          next,
  input  logic                          exit_view,
  input  logic                          clear,
  output logic [CHANNELS*WIDTH-1:0]     value_out,
  output logic [$clog2(DEPTH)-1:0]      view_age,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty,
  output logic                          viewing
);

  localparam int DW = CHANNELS * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(2 * DEPTH);

  localparam logic ST_LIVE = 1'b0;
  localparam logic ST_VIEW = 1'b1;

  logic [DW-1:0] r_mem [DEPTH];
  logic          r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_view_age;
  logic [DW-1:0] r_value_out;
  logic          r_full;
  logic          r_empty;
  logic          r_viewing;

  logic          w_state_nxt;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [AW-1:0] w_age_nxt;
  logic          w_do_store;
  logic [CW-1:0] w_count_m1;
  logic [AW-1:0] w_last_age;
  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_slot_wide;
  logic [AW-1:0] w_slot;

  assign w_count_m1 = r_count - CW'(1);
  assign w_last_age = w_count_m1[AW-1:0];

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    w_age_nxt    = r_view_age;
    w_do_store   = 1'b0;
    if (clear) begin
      w_state_nxt  = ST_LIVE;
      w_wr_ptr_nxt = '0;
      w_count_nxt  = '0;
      w_age_nxt    = '0;
    end else if (r_state == ST_LIVE) begin
      if (store) begin
        w_do_store   = 1'b1;
        w_wr_ptr_nxt = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
        if (r_count != CW'(DEPTH))
          w_count_nxt = r_count + CW'(1);
      end else if (recall && (r_count != '0)) begin
        w_state_nxt = ST_VIEW;
        w_age_nxt   = '0;
      end
    end else begin
      if (exit_view) begin
        w_state_nxt = ST_LIVE;
        w_age_nxt   = '0;
      end else if (prev) begin
        w_age_nxt = (r_view_age == w_last_age) ? '0 : r_view_age + AW'(1);
      end else if (next) begin
        w_age_nxt = (r_view_age == '0) ? w_last_age : r_view_age - AW'(1);
      end
    end
  end

  // Slot of the newly selected age: wr_ptr-1-age folded into [0,DEPTH) with a
  // single conditional subtract, so DEPTH need not be a power of two.
  assign w_sum       = SW'(r_wr_ptr) + SW'(DEPTH - 1) - SW'(w_age_nxt);
  assign w_slot_wide = (w_sum >= SW'(DEPTH)) ? w_sum - SW'(DEPTH) : w_sum;
  assign w_slot      = w_slot_wide[AW-1:0];

  // NOTE: the snapshot array is reset explicitly because a cleared history
  // must never expose power-up contents; this keeps it in flops, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_do_store) begin
      r_mem[r_wr_ptr] <= value_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LIVE;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_view_age  <= '0;
      r_value_out <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_viewing   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_count     <= w_count_nxt;
      r_view_age  <= w_age_nxt;
      r_value_out <= (w_state_nxt == ST_VIEW) ? r_mem[w_slot] : value_in;
      r_full      <= (w_count_nxt == CW'(DEPTH));
      r_empty     <= (w_count_nxt == '0);
      r_viewing   <= (w_state_nxt == ST_VIEW);
    end
  end

  assign value_out = r_value_out;
  assign view_age  = r_view_age;
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;
  assign viewing   = r_viewing;

endmodule
